password_lock: RTL and testbench
================================

PASSWORD_LOCK -- requirements
Module: password_lock

Interface
REQ-001 Parameter DEFAULT_CODE, 16'h1234, four BCD digits loaded as the stored code at reset; first entered digit in [15:12].
REQ-002 Parameter LOCKOUT_CYCLES, 1000, number of clk cycles spent in ALARM. Valid only with LOCKOUT_EN.
REQ-003 Port clk  in  1  single system clock; all state changes on posedge.
REQ-004 Port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Port key  in  4  key code from the upstream keypad scanner.
REQ-006 Port key_valid  in  1  one-cycle strobe; key is sampled only when key_valid=1.
REQ-007 Port unlocked  out  1  level output; 1 while in UNLOCKED or SET.
REQ-008 Port alarm  out  1  level output; 1 while in ALARM.
REQ-009 Port ok  out  1  one-cycle pulse on a successful unlock or a committed code change.
REQ-010 Port err  out  1  one-cycle pulse on a rejected Enter.
REQ-011 Port digit_cnt  out  3  number of digits currently buffered, 0..4.

Function
REQ-012 Key map: 0x0-0x9 digit; 0xA CLEAR; 0xB ENTER; 0xC SETCODE; 0xD LOCK; 0xE and 0xF ignored with no state change.
REQ-013 FSM states: LOCKED, UNLOCKED, SET, ALARM. All outputs are registered and update on the clk edge after key_valid, so latency is 1 cycle.
REQ-014 Digit in LOCKED or SET with digit_cnt<4: shift into the 16-bit buffer from the LSB side and increment digit_cnt. With digit_cnt=4 the digit is dropped and the buffer is unchanged.
REQ-015 CLEAR in LOCKED or SET: zero the buffer and set digit_cnt to 0. The state is unchanged.
REQ-016 ENTER in LOCKED with digit_cnt=4 and buffer=stored code: go to UNLOCKED, pulse ok, clear the buffer.
REQ-017 ENTER in LOCKED otherwise: stay in LOCKED, pulse err, clear the buffer, increment fail_cnt (saturating at 3).
REQ-018 UNLOCKED: SETCODE goes to SET. LOCK goes to LOCKED. Digits, CLEAR and ENTER are ignored.
REQ-019 ENTER in SET with digit_cnt=4: stored code takes the buffer value, go to UNLOCKED, pulse ok.
REQ-020 ENTER in SET with digit_cnt<4: stay in SET, pulse err.
REQ-021 Both ENTER outcomes in SET clear the buffer.
REQ-022 LOCK in SET: go to LOCKED with the stored code unchanged and the buffer cleared.
REQ-023 A successful unlock sets fail_cnt to 0.
REQ-024 ok and err are never both 1 in the same cycle.
REQ-025 key_valid held high for N cycles is treated as N key events.

Reset
REQ-026 rst_n=0 immediately forces: state LOCKED, stored code DEFAULT_CODE, buffer 0, digit_cnt 0, fail_cnt 0, lockout counter 0, unlocked/alarm/ok/err all 0. This applies from any state, including mid-entry and during ALARM.

Configuration
REQ-027 Macro PASSWORD_LOCKOUT_EN, when defined:
- The third consecutive failed ENTER goes to ALARM instead of LOCKED, on the same edge as its err pulse.
- In ALARM every key_valid is ignored for LOCKOUT_CYCLES cycles.
- On expiry the FSM goes to LOCKED and fail_cnt is set to 0.
REQ-028 Macro PASSWORD_LOCKOUT_EN, when not defined: the ALARM state and lockout counter are absent, alarm is tied to 0, and failures only pulse err.

Structure
REQ-029 Package password_pkg holds:
- the state enum;
- key code constants KEY_CLEAR, KEY_ENTER, KEY_SETCODE, KEY_LOCK;
- CODE_W=16 and DIGITS=4;
- MAX_FAILS=3.
REQ-030 A single sub-module lockout_timer (load, count down, done pulse) implements the ALARM duration. It is instantiated only under PASSWORD_LOCKOUT_EN.

Verification
REQ-031 Reset, then key 1,2,3,4,ENTER: ok pulses 1 cycle after ENTER, unlocked=1, digit_cnt returns to 0.
REQ-032 Key 1,2,3,5,ENTER: err pulses, unlocked stays 0. Then key 1,2,ENTER (digit_cnt=2): err pulses.
REQ-033 Unlock, SETCODE, 9,8,7,ENTER: err pulses and the state remains SET. Then CLEAR, 9,8,7,6,ENTER: ok pulses. Then LOCK, 1,2,3,4,ENTER: err pulses. Then 9,8,7,6,ENTER: unlocked=1.
REQ-034 Key 1,2,3,4,5: digit_cnt=4 and 5 is dropped. Then ENTER: unlocked=1. Key 0xE at any point causes no change.
REQ-035 With PASSWORD_LOCKOUT_EN and LOCKOUT_CYCLES=20, three wrong ENTERs: alarm=1. Correct code entered during ALARM is ignored. After 20 cycles alarm=0 and the correct code then unlocks.
REQ-036 rst_n pulsed low after 2 digits, and again mid-ALARM: all outputs are 0 immediately and the stored code reverts to 16'h1234.

Source files
------------

// File: rtl/password_lock_pkg.sv
// Shared definitions for the password lock: FSM states, key codes and sizes.
package password_pkg;

  localparam int         CODE_W    = 16;
  localparam logic [2:0] DIGITS    = 3'd4;
  localparam logic [1:0] MAX_FAILS = 2'd3;

  localparam logic [3:0] KEY_CLEAR   = 4'hA;
  localparam logic [3:0] KEY_ENTER   = 4'hB;
  localparam logic [3:0] KEY_SETCODE = 4'hC;
  localparam logic [3:0] KEY_LOCK    = 4'hD;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_SET      = 2'd2,
    ST_ALARM    = 2'd3
  } state_e;

  // Keys 0x0..0x9 are BCD digits; everything above is a command or ignored.
  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/password_lock_lockout_timer.sv
// Down-counter that times the ALARM lockout. load_i arms it with CYCLES;
// done_o is high during the last counted cycle so the owner can leave ALARM
// exactly CYCLES cycles after the load edge. Only used with PASSWORD_LOCKOUT_EN.
module lockout_timer #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic done_o
);

  localparam int CNT_W = ($clog2(CYCLES + 1) < 1) ? 1 : $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load on request, otherwise count down to zero and rest there.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/password_lock.sv
// Keypad password lock: 4-digit BCD code entry, unlock, code change and lock.
// Optional lockout after repeated failures is enabled by defining the macro
// PASSWORD_LOCKOUT_EN; without it the ALARM state is never entered and
// alarm is tied low.
module password_lock
  import password_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic       unlocked,
  output logic       alarm,
  output logic       ok,
  output logic       err,
  output logic [2:0] digit_cnt
);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   buf_q, buf_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [1:0]          fail_q, fail_d;
  logic                ok_q, ok_d;
  logic                err_q, err_d;
  logic                unlocked_q;

`ifdef PASSWORD_LOCKOUT_EN
  logic tmr_load;
  logic tmr_done;
  logic alarm_q;

  lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout_timer (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (tmr_load),
    .done_o (tmr_done)
  );
`endif

  // Next-state logic: one key event per cycle with key_valid high.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
`ifdef PASSWORD_LOCKOUT_EN
    tmr_load = 1'b0;
`endif
    case (state_q)
      ST_LOCKED, ST_SET: begin
        if (key_valid) begin
          if (is_digit(key)) begin
            // A fifth digit is dropped rather than shifting out the first.
            if (cnt_q < DIGITS) begin
              buf_d = {buf_q[CODE_W-5:0], key};
              cnt_d = cnt_q + 3'd1;
            end
          end else if (key == KEY_CLEAR) begin
            buf_d = '0;
            cnt_d = '0;
          end else if (key == KEY_ENTER) begin
            buf_d = '0;
            cnt_d = '0;
            if (state_q == ST_LOCKED) begin
              if (cnt_q == DIGITS && buf_q == code_q) begin
                state_d = ST_UNLOCKED;
                ok_d    = 1'b1;
                fail_d  = '0;
              end else begin
                err_d = 1'b1;
                if (fail_q != MAX_FAILS) begin
                  fail_d = fail_q + 2'd1;
                end
`ifdef PASSWORD_LOCKOUT_EN
                if (fail_q == MAX_FAILS - 2'd1) begin
                  state_d  = ST_ALARM;
                  tmr_load = 1'b1;
                end
`endif
              end
            end else begin
              if (cnt_q == DIGITS) begin
                code_d  = buf_q;
                state_d = ST_UNLOCKED;
                ok_d    = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
          end else if (key == KEY_LOCK && state_q == ST_SET) begin
            state_d = ST_LOCKED;
            buf_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_UNLOCKED: begin
        if (key_valid) begin
          if (key == KEY_SETCODE) begin
            state_d = ST_SET;
          end else if (key == KEY_LOCK) begin
            state_d = ST_LOCKED;
          end
        end
      end
      default: begin
`ifdef PASSWORD_LOCKOUT_EN
        // Keys are ignored until the lockout expires.
        if (tmr_done) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end
`else
        state_d = ST_LOCKED;
`endif
      end
    endcase
  end

  // State, code, buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOCKED;
      code_q     <= DEFAULT_CODE;
      buf_q      <= '0;
      cnt_q      <= '0;
      fail_q     <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      unlocked_q <= (state_d == ST_UNLOCKED) || (state_d == ST_SET);
    end
  end

`ifdef PASSWORD_LOCKOUT_EN
  // Registered alarm level, high for the whole lockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= (state_d == ST_ALARM);
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_lockout;
  assign unused_lockout = ^LOCKOUT_CYCLES;
  assign alarm          = 1'b0;
`endif

  assign unlocked  = unlocked_q;
  assign ok        = ok_q;
  assign err       = err_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_password_lock.sv
// Directed bench for password_lock with a behavioural reference model.
module tb_password_lock;

  localparam int LOCK_N = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       key_valid;
  logic       unlocked, alarm, ok, err;
  logic [2:0] digit_cnt;

  always #5 clk = ~clk;

  password_lock #(
    .DEFAULT_CODE   (16'h1234),
    .LOCKOUT_CYCLES (LOCK_N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .key_valid (key_valid),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .ok        (ok),
    .err       (err),
    .digit_cnt (digit_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_LOCKED, M_UNLOCKED, M_SET, M_ALARM} mstate_t;
  mstate_t m_st;
  int      m_code[4];
  int      m_dig[$];
  int      m_fails;
  int      m_left;
  bit      m_ok, m_err;

  task automatic m_reset();
    m_st    = M_LOCKED;
    m_code  = '{1, 2, 3, 4};
    m_dig.delete();
    m_fails = 0;
    m_left  = 0;
    m_ok    = 1'b0;
    m_err   = 1'b0;
  endtask

  function automatic bit m_match();
    if (m_dig.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (m_dig[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    m_ok  = 1'b0;
    m_err = 1'b0;
    if (!rst_n) begin
      m_reset();
      return;
    end
    if (m_st == M_ALARM) begin
      m_left--;
      if (m_left == 0) begin
        m_st    = M_LOCKED;
        m_fails = 0;
      end
      return;
    end
    if (!key_valid || key >= 4'hE) return;
    if (m_st == M_UNLOCKED) begin
      if (key == 4'hC) m_st = M_SET;
      else if (key == 4'hD) m_st = M_LOCKED;
      return;
    end
    if (key <= 4'h9) begin
      if (m_dig.size() < 4) m_dig.push_back(int'(key));
    end else if (key == 4'hA) begin
      m_dig.delete();
    end else if (key == 4'hB) begin
      if (m_st == M_LOCKED) begin
        if (m_match()) begin
          m_st    = M_UNLOCKED;
          m_ok    = 1'b1;
          m_fails = 0;
        end else begin
          m_err = 1'b1;
          if (m_fails < 3) m_fails++;
`ifdef PASSWORD_LOCKOUT_EN
          if (m_fails == 3) begin
            m_st   = M_ALARM;
            m_left = LOCK_N;
          end
`endif
        end
      end else begin
        if (m_dig.size() == 4) begin
          for (int i = 0; i < 4; i++) m_code[i] = m_dig[i];
          m_st = M_UNLOCKED;
          m_ok = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      m_dig.delete();
    end else if (key == 4'hD && m_st == M_SET) begin
      m_st = M_LOCKED;
      m_dig.delete();
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("unlocked", int'(unlocked), int'(m_st == M_UNLOCKED || m_st == M_SET));
        check("alarm", int'(alarm), int'(m_st == M_ALARM));
        check("ok", int'(ok), int'(m_ok));
        check("err", int'(err), int'(m_err));
        check("digit_cnt", int'(digit_cnt), m_dig.size());
        check("ok_err_excl", int'(ok && err), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [3:0] k);
    key       = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key       = 4'h0;
  endtask

  task automatic press4(input logic [3:0] a, b, c, d);
    press(a); press(b); press(c); press(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_unlocked"}, int'(unlocked), 0);
    check({tag, "_alarm"}, int'(alarm), 0);
    check({tag, "_ok"}, int'(ok), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_cnt"}, int'(digit_cnt), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; key = 4'h0; key_valid = 1'b0;
    #1 rst_n = 1'b0;
    #3 check_all_zero("reset");
    idle(2);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // correct code unlocks
    press4(4'h1, 4'h2, 4'h3, 4'h4);
    check("cnt_full", int'(digit_cnt), 4);
    press(4'hB);
    check("unlock_ok", int'(ok), 1);
    check("unlock_lvl", int'(unlocked), 1);
    check("unlock_cnt", int'(digit_cnt), 0);
    idle(1);
    check("ok_one_cycle", int'(ok), 0);
    press(4'hD);
    check("lock_lvl", int'(unlocked), 0);

    // wrong code and short entry
    press4(4'h1, 4'h2, 4'h3, 4'h5);
    press(4'hB);
    check("wrong_err", int'(err), 1);
    check("wrong_lvl", int'(unlocked), 0);
    press(4'h1); press(4'h2);
    check("short_cnt", int'(digit_cnt), 2);
    press(4'hB);
    check("short_err", int'(err), 1);

    // ignored key and dropped fifth digit
    press(4'h1); press(4'h2); press(4'hE);
    check("ignE_cnt", int'(digit_cnt), 2);
    press(4'h3); press(4'h4); press(4'h5);
    check("drop5_cnt", int'(digit_cnt), 4);
    press(4'hB);
    check("drop5_unlock", int'(unlocked), 1);
    press(4'hE);
    check("ignE_unlocked", int'(unlocked), 1);

    // code change
    press(4'hC);
    press(4'h9); press(4'h8); press(4'h7); press(4'hB);
    check("set_short_err", int'(err), 1);
    check("set_stays", int'(unlocked), 1);
    press(4'hA);
    check("clear_cnt", int'(digit_cnt), 0);
    press4(4'h9, 4'h8, 4'h7, 4'h6);
    press(4'hB);
    check("set_ok", int'(ok), 1);
    press(4'hD);
    press4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hB);
    check("old_code_err", int'(err), 1);
    press4(4'h9, 4'h8, 4'h7, 4'h6);
    press(4'hB);
    check("new_code_unlock", int'(unlocked), 1);

    // LOCK during SET keeps the stored code
    press(4'hC);
    press4(4'h5, 4'h5, 4'h5, 4'h5);
    press(4'hD);
    check("set_lock_lvl", int'(unlocked), 0);
    check("set_lock_cnt", int'(digit_cnt), 0);
    press4(4'h9, 4'h8, 4'h7, 4'h6);
    press(4'hB);
    check("code_kept", int'(unlocked), 1);

    // key_valid held for three cycles gives three digits
    press(4'hD);
    key = 4'h7; key_valid = 1'b1;
    idle(3);
    key_valid = 1'b0;
    check("held_cnt", int'(digit_cnt), 3);
    press(4'hA);

    // reset mid-entry restores the default code
    press(4'h1); press(4'h2);
    check("pre_rst_cnt", int'(digit_cnt), 2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    press4(4'h9, 4'h8, 4'h7, 4'h6);
    press(4'hB);
    check("rst_old_code_err", int'(err), 1);
    press4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hB);
    check("rst_default_unlock", int'(unlocked), 1);
    press(4'hD);

`ifdef PASSWORD_LOCKOUT_EN
    // three failures enter ALARM
    press(4'hB); press(4'hB);
    check("fail2_alarm", int'(alarm), 0);
    press(4'hB);
    check("fail3_err", int'(err), 1);
    check("fail3_alarm", int'(alarm), 1);
    press4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hB);
    check("alarm_ignores", int'(unlocked), 0);
    check("alarm_cnt", int'(digit_cnt), 0);
    idle(LOCK_N - 6);
    check("alarm_last", int'(alarm), 1);
    idle(1);
    check("alarm_expired", int'(alarm), 0);
    press4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hB);
    check("post_alarm_unlock", int'(unlocked), 1);

    // reset during ALARM
    press(4'hC);
    press4(4'h4, 4'h3, 4'h2, 4'h1);
    press(4'hB);
    press(4'hD);
    press(4'hB); press(4'hB); press(4'hB);
    check("alarm_again", int'(alarm), 1);
    idle(3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_alarm");
    @(negedge clk);
    rst_n = 1'b1;
    press4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hB);
    check("rst_alarm_unlock", int'(unlocked), 1);
`else
    // failures only pulse err without lockout
    press(4'hB); press(4'hB); press(4'hB);
    check("fail3_err", int'(err), 1);
    check("fail3_no_alarm", int'(alarm), 0);
    press(4'hB);
    check("fail4_err", int'(err), 1);
    press4(4'h1, 4'h2, 4'h3, 4'h4);
    press(4'hB);
    check("after_fails_unlock", int'(unlocked), 1);
`endif

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
